// File: rtl/boreal_hid_pkg.sv
// Shared definitions for the Boreal 8-byte HID report: byte map, CRC8 step, receiver FSM states.
package boreal_hid_pkg;

  localparam int HID_REPORT_BYTES = 8;

  localparam int IDX_BUTTONS  = 0;
  localparam int IDX_DX       = 1;
  localparam int IDX_DY       = 2;
  localparam int IDX_SAFETY   = 3;
  localparam int IDX_FRAME_ID = 4;
  localparam int IDX_STATUS   = 5;
  localparam int IDX_CRC      = 6;
  localparam int IDX_RSVD     = 7;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} hid_rx_state_e;

  // One byte of MSB-first CRC8 (no reflection, no final xor).
  function automatic logic [7:0] crc8_step8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/hid_frame_watchdog.sv
// Link watchdog: counts 1kHz ticks since the last good frame and drops link_ok when the link goes stale.
module hid_frame_watchdog #(
  parameter int STALE_TICKS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic good_i,
  output logic link_ok_o
);

  localparam int TICK_W = $clog2(STALE_TICKS + 1);

  logic [TICK_W-1:0] ticks_q, ticks_d;
  logic              link_ok_q, link_ok_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    ticks_d   = ticks_q;
    link_ok_d = link_ok_q;
    if (good_i) begin
      ticks_d   = '0;
      link_ok_d = 1'b1;
    end else if (tick_i && link_ok_q) begin
      if (ticks_q == TICK_W'(STALE_TICKS - 1)) begin
        ticks_d   = '0;
        link_ok_d = 1'b0;
      end else begin
        ticks_d = ticks_q + TICK_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ticks_q   <= '0;
      link_ok_q <= 1'b0;
    end else begin
      ticks_q   <= ticks_d;
      link_ok_q <= link_ok_d;
    end
  end

  assign link_ok_o = link_ok_q;

endmodule

// File: rtl/usb_hid_report_rx.sv
// Byte-serial Boreal HID report receiver: reassembles 8-byte frames, checks CRC8/format/sequence,
// and presents the last good report, zeroing motion while the link is stale.
module usb_hid_report_rx
  import boreal_hid_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 64,
  parameter int STALE_TICKS  = 5,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1khz,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  output logic [1:0]        buttons,
  output logic signed [7:0] dx,
  output logic signed [7:0] dy,
  output logic [3:0]        safety_flags,
  output logic [7:0]        frame_id,
  output logic [2:0]        symbolic_state,
  output logic              pkt_valid,
  output logic              crc_err,
  output logic              fmt_err,
  output logic              abort_err,
  output logic              seq_gap,
  output logic [CNT_W-1:0]  missed_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              link_ok
);

  localparam int GAP_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int IDX_W = $clog2(HID_REPORT_BYTES);

  hid_rx_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, wr_idx;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       crc_q, crc_d;
  logic             wr_en;
  logic [7:0]       byte_q [HID_REPORT_BYTES-1];

  logic [1:0]       buttons_q, buttons_d;
  logic [7:0]       dx_q, dx_d, dy_q, dy_d, id_q, id_d;
  logic [3:0]       safety_q, safety_d;
  logic [2:0]       sym_q, sym_d;
  logic             pkt_valid_q, pkt_valid_d, crc_err_q, crc_err_d, fmt_err_q, fmt_err_d;
  logic             abort_q, abort_d, seq_gap_q, seq_gap_d;
  logic [CNT_W-1:0] missed_q, missed_d, err_q, err_d;
  logic [CNT_W:0]   missed_sum, err_sum;
  logic [7:0]       exp_id, skipped;
  logic             crc_bad, fmt_bad, good, link_ok_w;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    crc_d       = crc_q;
    wr_en       = 1'b0;
    wr_idx      = idx_q;
    good        = 1'b0;
    pkt_valid_d = 1'b0;
    crc_err_d   = 1'b0;
    fmt_err_d   = 1'b0;
    abort_d     = 1'b0;
    seq_gap_d   = 1'b0;
    buttons_d   = buttons_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    safety_d    = safety_q;
    id_d        = id_q;
    sym_d       = sym_q;
    missed_d    = missed_q;
    err_d       = err_q;
    exp_id      = id_q + 8'd1;
    skipped     = byte_q[IDX_FRAME_ID] - exp_id;
    missed_sum  = {1'b0, missed_q} + (CNT_W + 1)'(skipped);
    err_sum     = {1'b0, err_q} + (CNT_W + 1)'(1);
    crc_bad     = (crc_q != byte_q[IDX_CRC]);
    // The reserved byte is never stored; it is judged as it arrives.
    fmt_bad     = (|byte_q[IDX_BUTTONS][7:2]) | (|byte_q[IDX_SAFETY][7:4]) |
                  (|byte_q[IDX_STATUS][7:3]) | (|rx_data);

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_sof) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          crc_d   = crc8_step8(8'h00, rx_data);
          idx_d   = IDX_W'(1);
          gap_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (rx_valid) begin
          gap_d = '0;
          if (rx_sof) begin
            abort_d = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = '0;
            crc_d   = crc8_step8(8'h00, rx_data);
            idx_d   = IDX_W'(1);
          end else if (idx_q == IDX_W'(IDX_RSVD)) begin
            state_d = CHECK;
            if (crc_bad) begin
              crc_err_d = 1'b1;
            end else if (fmt_bad) begin
              fmt_err_d = 1'b1;
            end else begin
              good        = 1'b1;
              pkt_valid_d = 1'b1;
              buttons_d   = byte_q[IDX_BUTTONS][1:0];
              dx_d        = byte_q[IDX_DX];
              dy_d        = byte_q[IDX_DY];
              safety_d    = byte_q[IDX_SAFETY][3:0];
              id_d        = byte_q[IDX_FRAME_ID];
              sym_d       = byte_q[IDX_STATUS][2:0];
              // Sequence checking is armed exactly while the link is up.
              if (link_ok_w && (byte_q[IDX_FRAME_ID] != exp_id)) begin
                seq_gap_d = 1'b1;
                missed_d  = missed_sum[CNT_W] ? '1 : missed_sum[CNT_W-1:0];
              end
            end
          end else begin
            wr_en = 1'b1;
            if (idx_q < IDX_W'(IDX_CRC)) crc_d = crc8_step8(crc_q, rx_data);
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (gap_q == GAP_W'(BYTE_TIMEOUT - 1)) begin
          abort_d = 1'b1;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (crc_err_d || fmt_err_d || abort_d) begin
      err_d = err_sum[CNT_W] ? err_q : err_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      crc_q       <= '0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      safety_q    <= '0;
      id_q        <= '0;
      sym_q       <= '0;
      pkt_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      seq_gap_q   <= 1'b0;
      missed_q    <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      crc_q       <= crc_d;
      buttons_q   <= buttons_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      safety_q    <= safety_d;
      id_q        <= id_d;
      sym_q       <= sym_d;
      pkt_valid_q <= pkt_valid_d;
      crc_err_q   <= crc_err_d;
      fmt_err_q   <= fmt_err_d;
      abort_q     <= abort_d;
      seq_gap_q   <= seq_gap_d;
      missed_q    <= missed_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the byte buffer has no reset; it is only read after the FSM has rewritten it for the frame.
  always_ff @(posedge clk) begin
    if (wr_en) byte_q[wr_idx] <= rx_data;
  end

  hid_frame_watchdog #(
    .STALE_TICKS(STALE_TICKS)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick_1khz),
    .good_i   (good),
    .link_ok_o(link_ok_w)
  );

  assign link_ok        = link_ok_w;
  assign buttons        = link_ok_w ? buttons_q : 2'b00;
  assign dx             = link_ok_w ? dx_q : 8'sd0;
  assign dy             = link_ok_w ? dy_q : 8'sd0;
  assign safety_flags   = safety_q;
  assign frame_id       = id_q;
  assign symbolic_state = sym_q;
  assign pkt_valid      = pkt_valid_q;
  assign crc_err        = crc_err_q;
  assign fmt_err        = fmt_err_q;
  assign abort_err      = abort_q;
  assign seq_gap        = seq_gap_q;
  assign missed_cnt     = missed_q;
  assign err_cnt        = err_q;

endmodule
